// File: rtl/hilo_muldiv_pkg.sv
// Shared MIPS encodings for the HI/LO multiply-divide unit: operation
// select values, FSM state codes and the iteration count of the datapath.
package hilo_muldiv_pkg;

   // Operation select
   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   // One radix-2 step per bit of a 32-bit operand
   localparam int ITERATIONS = 32;

   // Magnitude of an operand, treating it as two's complement only for signed ops.
   // 0x80000000 maps to itself, which is its correct unsigned magnitude.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? 32'(-v) : v;
   endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the pipeline control and the HI/LO unit.
interface hilo_muldiv_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        mthi;
   logic        mtlo;
   logic [31:0] mt_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, operand_a, operand_b, mthi, mtlo, mt_data,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, operand_a, operand_b, mthi, mtlo, mt_data,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit. Operands are reduced to magnitudes
// on start, 32 unsigned shift-add or restoring-subtract steps run in CALC on
// one shared 64-bit accumulator and 33-bit adder, and FIX applies the signs
// and writes HI/LO.
module hilo_muldiv
   import hilo_muldiv_pkg::*;
(
   input logic          clk,
   input logic          rst,
   hilo_muldiv_if.slave bus
);

   logic [1:0]  state;
   logic [4:0]  count;
   logic [63:0] acc;
   logic [31:0] operand_reg;
   logic        op_is_div;
   logic        neg_lo;
   logic        neg_hi;
   logic        div_zero;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   logic        req_signed;
   logic        req_div;
   logic        req_zero;
   logic [32:0] add_a;
   logic [32:0] add_b;
   logic [32:0] add_sum;
   logic [63:0] acc_step;
   logic [63:0] prod_fixed;
   logic [31:0] quo_fixed;
   logic [31:0] rem_fixed;
   logic [31:0] fix_hi;
   logic [31:0] fix_lo;

   assign req_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign req_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
   assign req_zero   = req_div && (bus.operand_b == 32'd0);

   // Shared 33-bit adder: adds the multiplicand to the upper half for
   // multiply, subtracts the divisor from the shifted remainder for divide.
   always_comb begin
      add_a   = op_is_div ? acc[63:31] : {1'b0, acc[63:32]};
      add_b   = op_is_div ? ~{1'b0, operand_reg} : {1'b0, operand_reg};
      add_sum = add_a + add_b + {32'd0, op_is_div};
   end

   // One iteration step; for divide a clear bit 32 means no borrow because
   // the shifted remainder is always below twice the divisor.
   always_comb begin
      acc_step = acc;
      if (op_is_div) begin
         if (!add_sum[32]) acc_step = {add_sum[31:0], acc[30:0], 1'b1};
         else              acc_step = {acc[62:0], 1'b0};
      end else begin
         if (acc[0]) acc_step = {add_sum, acc[31:1]};
         else        acc_step = {1'b0, acc[63:1]};
      end
   end

   // Sign correction of the unsigned result; a zero divisor bypasses the
   // datapath and returns all-ones with the raw dividend held in operand_reg.
   always_comb begin
      prod_fixed = neg_lo ? 64'(-acc) : acc;
      quo_fixed  = neg_lo ? 32'(-acc[31:0]) : acc[31:0];
      rem_fixed  = neg_hi ? 32'(-acc[63:32]) : acc[63:32];
      fix_hi     = prod_fixed[63:32];
      fix_lo     = prod_fixed[31:0];
      if (op_is_div) begin
         if (div_zero) begin
            fix_hi = operand_reg;
            fix_lo = 32'hFFFF_FFFF;
         end else begin
            fix_hi = rem_fixed;
            fix_lo = quo_fixed;
         end
      end
   end

   // Control FSM, operand capture, iteration and HI/LO write-back; mthi/mtlo
   // are only honoured in IDLE and coexist with an accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         count       <= 5'd0;
         acc         <= 64'd0;
         operand_reg <= 32'd0;
         op_is_div   <= 1'b0;
         neg_lo      <= 1'b0;
         neg_hi      <= 1'b0;
         div_zero    <= 1'b0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.mthi) hi_q <= bus.mt_data;
               if (bus.mtlo) lo_q <= bus.mt_data;
               if (bus.start) begin
                  state       <= ST_CALC;
                  count       <= 5'(ITERATIONS - 1);
                  op_is_div   <= req_div;
                  neg_lo      <= req_signed && (bus.operand_a[31] ^ bus.operand_b[31]);
                  neg_hi      <= req_signed && bus.operand_a[31];
                  div_zero    <= req_zero;
                  acc         <= {32'd0, mag32(bus.operand_a, req_signed)};
                  operand_reg <= req_zero ? bus.operand_a
                                          : mag32(bus.operand_b, req_signed);
               end
            end
            ST_CALC: begin
               acc   <= acc_step;
               count <= count - 5'd1;
               if (count == 5'd0) state <= ST_FIX;
            end
            ST_FIX: begin
               hi_q   <= fix_hi;
               lo_q   <= fix_lo;
               done_q <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = (state != ST_IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner cases plus random
// operations compared against a plain 64-bit arithmetic reference model.
module tb_hilo_muldiv;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   logic [63:0] result;

   hilo_muldiv_if bus();

   hilo_muldiv dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Last-resort guard against a hung run
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model built from the arithmetic definitions of each operation
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] ua;
      logic [63:0] ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         2'd0:    return 64'(sa * sb);
         2'd1:    return ua * ub;
         2'd2:    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                  else return {32'(sa % sb), 32'(sa / sb)};
         default: if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                  else return {32'(ua % ub), 32'(ua / ub)};
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Presents an operation for one cycle; afterwards we are in cycle 1
   task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
      bus.op        = o;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      cyc           = 1;
   endtask

   // Waits (bounded) for done, checking busy stays high until then
   task automatic wait_done();
      logic busy_ok;
      busy_ok = 1'b1;
      while (bus.done !== 1'b1 && cyc < 45) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         tick();
         cyc++;
      end
      check_output("busy_during_op", 64'(busy_ok), 64'd1);
      check_output("done_cycle", 64'(cyc), 64'd34);
      check_output("busy_at_done", 64'(bus.busy), 64'd0);
   endtask

   // Full operation checked against the model; leaves us in the done cycle
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, output logic [63:0] res);
      apply_stimulus(o, a, b);
      wait_done();
      res = {bus.hi, bus.lo};
      check_output(tag, res, model(o, a, b));
   endtask

   initial begin
      int done_seen;
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;

      bus.start = 1'b0; bus.op = 2'd0; bus.operand_a = 32'd0; bus.operand_b = 32'd0;
      bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mt_data = 32'd0;

      // Reset state
      tick(); tick();
      rst = 1'b0;
      check_output("reset_busy", 64'(bus.busy), 64'd0);
      check_output("reset_done", 64'(bus.done), 64'd0);
      check_output("reset_hilo", {bus.hi, bus.lo}, 64'd0);

      // mthi and mtlo together while idle
      bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'h1234_5678;
      tick();
      bus.mthi = 1'b0; bus.mtlo = 1'b0;
      check_output("mthi_mtlo", {bus.hi, bus.lo}, 64'h12345678_12345678);

      // Directed arithmetic corners with literal expectations
      run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0005, result);
      check_output("mult_neg_const", result, 64'hFFFFFFFF_FFFFFFF1);
      run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, result);
      check_output("multu_max_const", result, 64'hFFFFFFFE_00000001);
      run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, result);
      check_output("div_neg_const", result, 64'hFFFFFFFF_FFFFFFFD);
      run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, result);
      check_output("div_ovf_const", result, 64'h00000000_80000000);
      run_op("divu_zero", 2'd3, 32'd100, 32'd0, result);
      check_output("divu_zero_const", result, 64'h00000064_FFFFFFFF);
      run_op("div_zero_neg", 2'd2, 32'hFFFF_FF00, 32'd0, result);

      // Second start plus mthi mid-operation must be ignored
      tick();
      apply_stimulus(2'd1, 32'd7, 32'd6);
      while (cyc < 5) begin tick(); cyc++; end
      bus.start = 1'b1; bus.op = 2'd0; bus.operand_a = 32'd3; bus.operand_b = 32'd3;
      bus.mthi = 1'b1; bus.mt_data = 32'hDEAD_BEEF;
      tick(); cyc++;
      bus.start = 1'b0; bus.mthi = 1'b0;
      wait_done();
      check_output("ignored_start", {bus.hi, bus.lo}, 64'd42);
      tick();
      check_output("done_single_pulse", 64'(bus.done), 64'd0);
      check_output("no_restart", 64'(bus.busy), 64'd0);

      // Reset at cycle 10 aborts the operation
      apply_stimulus(2'd1, 32'd7, 32'd6);
      while (cyc < 10) begin tick(); cyc++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_output("abort_busy", 64'(bus.busy), 64'd0);
      check_output("abort_hilo", {bus.hi, bus.lo}, 64'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) done_seen++;
         tick();
      end
      check_output("abort_no_done", 64'(done_seen), 64'd0);

      // mthi with start in the same idle cycle: both take effect
      bus.mthi = 1'b1; bus.mt_data = 32'hCAFE_0001;
      apply_stimulus(2'd1, 32'd9, 32'd9);
      bus.mthi = 1'b0;
      check_output("mthi_with_start", {bus.hi, 31'd0, bus.busy}, {32'hCAFE_0001, 32'd1});
      wait_done();
      check_output("mthi_start_result", {bus.hi, bus.lo}, 64'd81);

      // Back-to-back: second start on the done cycle, second result at cycle 68
      run_op("b2b_first", 2'd0, 32'hFFFF_FFF0, 32'd3, result);
      run_op("b2b_second", 2'd3, 32'd1000, 32'd7, result);

      // Random operations, issued back-to-back, with frequent zero divisors
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
         run_op("random_op", ro, ra, rb, result);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
